// File: rtl/char_freq_counter.sv
// char_freq_counter: byte-stream histogram with saturating counts, stable odd-even sort, held until taken.
module char_freq_counter #(
  parameter int MAX_CHAR_COUNT = 5,
  parameter int FREQ_W = 3,
  localparam int UW = $clog2(MAX_CHAR_COUNT + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    char_in,
  input  logic                          char_valid,
  input  logic                          char_last,
  output logic                          char_ready,
  output logic [8*MAX_CHAR_COUNT-1:0]   data_out,
  output logic [FREQ_W*MAX_CHAR_COUNT-1:0] freq_out,
  output logic [UW-1:0]                 uniq_count,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          overflow
);
  localparam int N = MAX_CHAR_COUNT;
  typedef enum logic [1:0] {IDLE, ACCUM, SORT, HOLD} state_t;
  state_t state, state_nxt;
  logic [7:0] ch [N];
  logic [7:0] ch_nxt [N];
  logic [FREQ_W-1:0] fq [N];
  logic [FREQ_W-1:0] fq_nxt [N];
  logic [UW-1:0] uniq, uniq_nxt, pass, pass_nxt;
  logic ov, ov_nxt, accept, hit_any;
  logic [N-1:0] occ, hit;
  assign char_ready = (state == IDLE) || (state == ACCUM);
  assign out_valid = state == HOLD;
  assign accept = char_valid & char_ready;
  assign uniq_count = uniq;
  assign overflow = ov;
  assign hit_any = |hit;
  for (genvar g = 0; g < N; g++) begin : g_pack
    assign data_out[8*g +: 8] = ch[g];
    assign freq_out[FREQ_W*g +: FREQ_W] = fq[g];
  end
  always_comb begin
    occ = '0;
    hit = '0;
    for (int i = 0; i < N; i++) begin
      occ[i] = UW'(i) < uniq;
      hit[i] = occ[i] && (ch[i] == char_in);
    end
  end
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, ACCUM: if (accept) state_nxt = char_last ? SORT : ACCUM;
      SORT: if (pass == UW'(N - 1)) state_nxt = HOLD;
      HOLD: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    ch_nxt = ch;
    fq_nxt = fq;
    uniq_nxt = uniq;
    ov_nxt = ov;
    pass_nxt = pass;
    if (accept) begin
      pass_nxt = '0;
      for (int i = 0; i < N; i++)
        if (hit[i]) fq_nxt[i] = &fq[i] ? fq[i] : fq[i] + FREQ_W'(1);
      if (!hit_any && uniq == UW'(N)) ov_nxt = 1'b1;
      else if (!hit_any) begin
        for (int i = 0; i < N; i++)
          if (UW'(i) == uniq) begin
            ch_nxt[i] = char_in;
            fq_nxt[i] = FREQ_W'(1);
          end
        uniq_nxt = uniq + UW'(1);
      end
    end else if (state == SORT) begin
      pass_nxt = pass + UW'(1);
      // Strict compare keeps ties in first-appearance order; occ[i+1] implies occ[i].
      for (int i = 0; i < N - 1; i++)
        if (i[0] == pass[0] && occ[i+1] && fq[i] > fq[i+1]) begin
          ch_nxt[i] = ch[i+1];
          ch_nxt[i+1] = ch[i];
          fq_nxt[i] = fq[i+1];
          fq_nxt[i+1] = fq[i];
        end
    end else if (state == HOLD && out_ready) begin
      for (int i = 0; i < N; i++) begin
        ch_nxt[i] = '0;
        fq_nxt[i] = '0;
      end
      uniq_nxt = '0;
      ov_nxt = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        ch[i] <= '0;
        fq[i] <= '0;
      end
      uniq <= '0;
      ov <= 1'b0;
      pass <= '0;
    end else begin
      ch <= ch_nxt;
      fq <= fq_nxt;
      uniq <= uniq_nxt;
      ov <= ov_nxt;
      pass <= pass_nxt;
    end
endmodule

// File: tb/tb_char_freq_counter.sv
// tb_char_freq_counter: table vectors, random messages vs a histogram+stable-sort model, stall and reset sequences.
module tb_char_freq_counter;
  logic clk = 0, reset = 0;
  logic [7:0] char_in = 0;
  logic char_valid = 0, char_last = 0, char_ready, out_valid, out_ready = 0, overflow;
  logic [39:0] data_out;
  logic [14:0] freq_out;
  logic [2:0] uniq_count;
  int errs = 0, checks = 0;
  char_freq_counter dut (
    .clk(clk), .reset(reset), .char_in(char_in), .char_valid(char_valid), .char_last(char_last),
    .char_ready(char_ready), .data_out(data_out), .freq_out(freq_out), .uniq_count(uniq_count),
    .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [95:0] msg;
    int len;
    logic [39:0] d;
    logic [14:0] f;
    int u;
    bit ov;
  } vec_t;
  vec_t vt[4];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic send(input logic [95:0] m, input int n);
    for (int k = 0; k < n; k++) begin
      char_valid = 1;
      char_in = m[8*(n-1-k) +: 8];
      char_last = (k == n - 1);
      @(posedge clk);
      #1;
    end
    char_valid = 0;
    char_last = 0;
  endtask
  task automatic wait_valid(input string tag);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'd5);
  endtask
  task automatic run_msg(input string tag, input logic [95:0] m, input int n, input logic [39:0] ed,
                         input logic [14:0] ef, input int eu, input bit eov);
    send(m, n);
    wait_valid(tag);
    chk({tag, " data"}, 64'(data_out), 64'(ed));
    chk({tag, " freq"}, 64'(freq_out), 64'(ef));
    chk({tag, " uniq"}, 64'(uniq_count), 64'(eu));
    chk({tag, " ovf"}, 64'(overflow), 64'(eov));
    chk({tag, " ready"}, 64'(char_ready), 64'd0);
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
    chk({tag, " clear"}, 64'({data_out, freq_out, uniq_count, overflow, out_valid, char_ready}), 64'd1);
  endtask
  function automatic void model(input logic [95:0] m, input int n, output logic [39:0] d,
                                output logic [14:0] f, output int u, output bit ov);
    logic [7:0] uc[$];
    int cn[$];
    int j, best;
    ov = 0;
    for (int k = 0; k < n; k++) begin
      logic [7:0] c = m[8*(n-1-k) +: 8];
      j = -1;
      foreach (uc[x]) if (uc[x] == c) j = x;
      if (j >= 0) cn[j] = (cn[j] < 7) ? cn[j] + 1 : 7;
      else if (uc.size() < 5) begin
        uc.push_back(c);
        cn.push_back(1);
      end else ov = 1;
    end
    u = uc.size();
    d = '0;
    f = '0;
    for (int s = 0; s < u; s++) begin
      best = 0;
      foreach (cn[x]) if (cn[x] < cn[best]) best = x;
      d[8*s +: 8] = uc[best];
      f[3*s +: 3] = 3'(cn[best]);
      uc.delete(best);
      cn.delete(best);
    end
  endfunction
  initial begin
    logic [95:0] m;
    logic [39:0] ed;
    logic [14:0] ef;
    int eu, n;
    bit eov;
    vt[0] = '{"abc", 3, {16'h0, "c", "b", "a"}, {3'd0, 3'd0, 3'd1, 3'd1, 3'd1}, 3, 1'b0};
    vt[1] = '{"anusha", 6, {"a", "h", "s", "u", "n"}, {3'd2, 3'd1, 3'd1, 3'd1, 3'd1}, 5, 1'b0};
    vt[2] = '{"aaaaaaaaa", 9, {32'h0, "a"}, {12'h0, 3'd7}, 1, 1'b0};
    vt[3] = '{"abcdef", 6, {"e", "d", "c", "b", "a"}, {3'd1, 3'd1, 3'd1, 3'd1, 3'd1}, 5, 1'b1};
    #12;
    chk("reset outs", 64'({data_out, freq_out, uniq_count, overflow, out_valid}), 64'd0);
    reset = 1;
    #3;
    chk("reset ready", 64'(char_ready), 64'd1);
    @(posedge clk);
    #1;
    foreach (vt[v]) run_msg($sformatf("vec%0d", v), vt[v].msg, vt[v].len, vt[v].d, vt[v].f, vt[v].u, vt[v].ov);
    for (int r = 0; r < 40; r++) begin
      n = $urandom_range(1, 12);
      m = '0;
      for (int k = 0; k < n; k++) begin
        int sel = $urandom_range(0, 6);
        m[8*(n-1-k) +: 8] = (sel == 6) ? 8'h00 : 8'h41 + 8'(sel);
      end
      model(m, n, ed, ef, eu, eov);
      run_msg($sformatf("rnd%0d", r), m, n, ed, ef, eu, eov);
    end
    send("aabb", 4);
    wait_valid("hold");
    char_valid = 1;
    char_in = "x";
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("hold stable", 64'({data_out, freq_out, uniq_count, out_valid, char_ready}),
          64'({24'h0, "b", "a", 9'h0, 3'd2, 3'd2, 3'd2, 1'b1, 1'b0}));
    end
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
    chk("handshake clear", 64'({data_out, uniq_count, out_valid, char_ready}), 64'd1);
    @(posedge clk);
    #1;
    char_valid = 0;
    chk("held char taken", 64'({data_out[7:0], freq_out[2:0], uniq_count}), 64'({8'h78, 3'd1, 3'd1}));
    run_msg("after hold", "x", 1, {32'h0, "x"}, {12'h0, 3'd2}, 1, 1'b0);
    send("anusha", 6);
    @(posedge clk);
    #2;
    reset = 0;
    #1;
    chk("abort outs", 64'({data_out, freq_out, uniq_count, overflow, out_valid}), 64'd0);
    #2;
    reset = 1;
    @(posedge clk);
    #1;
    chk("abort idle", 64'({out_valid, char_ready}), 64'd1);
    run_msg("post reset", "ab", 2, {24'h0, "b", "a"}, {9'h0, 3'd1, 3'd1}, 2, 1'b0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
